// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the four-slave APB responder.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int NUM_SLAVES = 4;
    localparam int ERR_CNT_W  = 8;

    // True when exactly one of the four select bits is set.
    function automatic logic onehot4(input logic [3:0] sel);
        return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// DEPTH x 32 register bank with one synchronous write port and one registered read port.
// Latency: write lands at the enabling edge; read data appears 1 cycle after i_re.
// Backpressure: none; both ports accept every cycle. o_rdat holds between reads.
//
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset (words -> RST_VAL, o_rdat -> 0)
//   i_we/i_waddr/i_wdat  write strobe, word index, data
//   i_re/i_raddr         read strobe, word index
//   o_rdat               registered read data
module apb_slave_regbank #(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [31:0]              i_wdat,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [31:0]              o_rdat
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
            r_rdat <= 32'h0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdat;
            end
            if (i_re) begin
                r_rdat <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/apb_slave_bank.sv
// APB responder for four peripherals: decodes one-hot Pselx, tracks SETUP/ACCESS, commits
// writes into four register banks and flags protocol violations from the bridge.
// Latency: zero wait states; read data valid 1 cycle after setup edge, xfer_done 1 cycle after
// ACCESS entry. Backpressure: none (PREADY is implicitly always high).
//
// Ports:
//   Hclk, Hresetn   clock, async active-low reset
//   Pselx[3:0]      one-hot slave select
//   Penable         access-phase strobe
//   Pwrite          1 = write, 0 = read
//   Paddr[31:0]     byte address; word index = Paddr[log2(DEPTH)+1:2], upper bits alias
//   Pwdata[31:0]    write data
//   Prdata[31:0]    read data, loaded at setup entry and held until the next read load
//   xfer_done       one-cycle pulse per legal completed transfer
//   prot_err        one-cycle pulse per cycle in which a violation is seen
//   err_cnt[7:0]    saturating violation count
module apb_slave_bank
    import apb_slave_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    input  logic [3:0]           Pselx,
    input  logic                 Penable,
    input  logic                 Pwrite,
    input  logic [31:0]          Paddr,
    input  logic [31:0]          Pwdata,
    output logic [31:0]          Prdata,
    output logic                 xfer_done,
    output logic                 prot_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    apb_state_e           r_state;
    logic [3:0]           r_sel;
    logic [31:0]          r_addr;
    logic                 r_write;
    logic [31:0]          r_wdata;
    logic                 r_xfer_done;
    logic                 r_prot_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic       w_valid;
    logic       w_multi;
    logic       w_match;
    logic       w_start;   // latch a new request and load read data
    logic       w_commit;  // enter ACCESS, perform the write if any
    logic       w_viol;
    apb_state_e w_next;

    logic [NUM_SLAVES-1:0] w_we;
    logic [NUM_SLAVES-1:0] w_re;
    logic [31:0]           w_rdat [NUM_SLAVES];

    assign w_valid = onehot4(Pselx);
    assign w_multi = (Pselx != 4'd0) && !w_valid;
    assign w_match = (Pselx == r_sel) && (Paddr == r_addr) &&
                     (Pwrite == r_write) && (Pwdata == r_wdata);

    always_comb begin
        w_start  = 1'b0;
        w_commit = 1'b0;
        w_viol   = 1'b0;
        w_next   = IDLE;
        if (w_multi) begin
            w_viol = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Penable with no setup behind it, with or without a select
                    if (Penable)      w_viol  = 1'b1;
                    else if (w_valid) w_start = 1'b1;
                end
                SETUP: begin
                    if (!w_valid) begin
                        w_viol = 1'b1;
                    end else if (!Penable) begin
                        // repeated setup: flagged, but the new request replaces the old one
                        w_viol  = 1'b1;
                        w_start = 1'b1;
                    end else if (w_match) begin
                        w_commit = 1'b1;
                    end else begin
                        w_viol = 1'b1;
                    end
                end
                ACCESS: begin
                    // Pselx == 0 is the normal return to IDLE
                    if (w_valid) begin
                        if (Penable) w_viol  = 1'b1;
                        else         w_start = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w_start) begin
            w_next = SETUP;
            // misaligned address is reported but the transfer proceeds on the truncated index
            if (Paddr[1:0] != 2'b00) w_viol = 1'b1;
        end
        if (w_commit) begin
            w_next = ACCESS;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= IDLE;
            r_sel       <= 4'd0;
            r_addr      <= 32'h0;
            r_write     <= 1'b0;
            r_wdata     <= 32'h0;
            r_xfer_done <= 1'b0;
            r_prot_err  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_next;
            r_xfer_done <= w_commit;
            r_prot_err  <= w_viol;
            if (w_viol && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_ONE;
            end
            if (w_start) begin
                r_sel   <= Pselx;
                r_addr  <= Paddr;
                r_write <= Pwrite;
                r_wdata <= Pwdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bank
        // Write uses the latched request; read uses the live bus at the setup edge so the
        // data is ready for the whole access cycle. The two never coincide on one edge.
        assign w_we[g] = w_commit && r_write && r_sel[g];
        assign w_re[g] = w_start && Pselx[g];

        apb_slave_regbank #(
            .DEPTH   (DEPTH),
            .RST_VAL (RST_VAL)
        ) u_bank (
            .i_clk   (Hclk),
            .i_rst_n (Hresetn),
            .i_we    (w_we[g]),
            .i_waddr (r_addr[AW+1:2]),
            .i_wdat  (r_wdata),
            .i_re    (w_re[g]),
            .i_raddr (Paddr[AW+1:2]),
            .o_rdat  (w_rdat[g])
        );
    end

    // r_sel only ever changes together with a read load into the newly selected bank, so
    // muxing by it keeps Prdata equal to the last value read. After reset r_sel is 0.
    always_comb begin
        Prdata = 32'h0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) Prdata = Prdata | w_rdat[i];
        end
    end

    assign xfer_done = r_xfer_done;
    assign prot_err  = r_prot_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_apb_slave_bank.sv
module tb_apb_slave_bank;

    localparam int          DEPTH = 16;
    localparam logic [31:0] RV    = 32'h5A5A_0F0F;

    logic        Hclk    = 1'b0;
    logic        Hresetn = 1'b0;
    logic [3:0]  Pselx   = 4'd0;
    logic        Penable = 1'b0;
    logic        Pwrite  = 1'b0;
    logic [31:0] Paddr   = 32'h0;
    logic [31:0] Pwdata  = 32'h0;
    logic [31:0] Prdata;
    logic        xfer_done;
    logic        prot_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    apb_slave_bank #(.DEPTH(DEPTH), .RST_VAL(RV)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .xfer_done (xfer_done),
        .prot_err  (prot_err),
        .err_cnt   (err_cnt)
    );

    always #5 Hclk = ~Hclk;

    // ---------------- reference model ----------------
    // Bus phase: 0 = nothing pending, 1 = request announced, 2 = data phase done.
    int          m_ph;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic        m_wr;
    logic [31:0] m_wd;
    logic [31:0] m_mem [4][DEPTH];
    logic [31:0] m_rd;
    logic        m_done;
    logic        m_err;
    int          m_cnt;

    function automatic int slave_of(input logic [3:0] s);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) if (s[k]) r = k;
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_sel = 4'd0; m_addr = 32'h0; m_wr = 1'b0; m_wd = 32'h0;
        m_rd = 32'h0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < DEPTH; w++) m_mem[s][w] = RV;
    endtask

    task automatic model_clk(input logic [3:0] s, input logic en, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
        int n;
        bit bad, start, commit;
        int nph;
        n = $countones(s);
        bad = 0; start = 0; commit = 0; nph = 0;
        m_done = 1'b0;
        if (n > 1) bad = 1;
        else if (m_ph == 0) begin
            if (en) bad = 1;
            else if (n == 1) start = 1;
        end else if (m_ph == 1) begin
            if (n == 0) bad = 1;
            else if (!en) begin bad = 1; start = 1; end
            else if (s == m_sel && a == m_addr && wr == m_wr && d == m_wd) commit = 1;
            else bad = 1;
        end else begin
            if (n == 1) begin
                if (en) bad = 1;
                else start = 1;
            end
        end
        if (start) begin
            if (a % 4 != 0) bad = 1;
            m_sel = s; m_addr = a; m_wr = wr; m_wd = d;
            m_rd = m_mem[slave_of(s)][word_of(a)];
            nph = 1;
        end
        if (commit) begin
            if (m_wr) m_mem[slave_of(m_sel)][word_of(m_addr)] = m_wd;
            m_done = 1'b1;
            nph = 2;
        end
        m_err = bad;
        if (bad && m_cnt < 255) m_cnt++;
        m_ph = nph;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive, let the DUT take the edge, return at the next negedge.
    task automatic apply(input logic [3:0] s, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        Pselx = s; Penable = en; Pwrite = wr; Paddr = a; Pwdata = d;
        @(posedge Hclk);
        model_clk(s, en, wr, a, d);
        @(negedge Hclk);
    endtask

    task automatic step(input logic [3:0] s, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        apply(s, en, wr, a, d);
        chk("model Prdata",    Prdata,          m_rd);
        chk("model xfer_done", 32'(xfer_done),  32'(m_done));
        chk("model prot_err",  32'(prot_err),   32'(m_err));
        chk("model err_cnt",   32'(err_cnt),    32'(m_cnt));
    endtask

    task automatic idle();
        step(4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        Hresetn = 1'b0;
        Pselx = 4'd0; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0; Pwdata = 32'h0;
        model_reset();
        @(negedge Hclk);
        chk("reset Prdata",    Prdata,         32'h0);
        chk("reset xfer_done", 32'(xfer_done), 32'h0);
        chk("reset prot_err",  32'(prot_err),  32'h0);
        chk("reset err_cnt",   32'(err_cnt),   32'h0);
        Hresetn = 1'b1;
        @(negedge Hclk);
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] e_rd;
        logic        e_done;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t        tbl [7];
    logic [3:0]  s;
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] d;
    logic        wr;
    int          kind;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // write slave 1 word 2, read it back, then a misaligned read of slave 0
        tbl[0] = '{4'b0010, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, RV,           1'b0, 1'b0, 8'd0};
        tbl[1] = '{4'b0010, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, RV,           1'b1, 1'b0, 8'd0};
        tbl[2] = '{4'b0010, 1'b0, 1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{4'b0010, 1'b1, 1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{4'b0000, 1'b0, 1'b0, 32'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 8'd0};
        tbl[5] = '{4'b0001, 1'b0, 1'b0, 32'h9, 32'h0,         RV,           1'b0, 1'b1, 8'd1};
        tbl[6] = '{4'b0001, 1'b1, 1'b0, 32'h9, 32'h0,         RV,           1'b1, 1'b0, 8'd1};

        @(negedge Hclk);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].sel, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d Prdata", i),    Prdata,         tbl[i].e_rd);
            chk($sformatf("tbl%0d xfer_done", i), 32'(xfer_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d prot_err", i),  32'(prot_err),  32'(tbl[i].e_err));
            chk($sformatf("tbl%0d err_cnt", i),   32'(err_cnt),   32'(tbl[i].e_cnt));
        end
        idle();

        // back-to-back writes to word 3 of every slave, then back-to-back reads
        for (int n = 0; n < 4; n++) begin
            s = 4'(1 << n);
            v = 32'(32'h1111_1111 * (n + 1));
            step(s, 1'b0, 1'b1, 32'hC, v);
            step(s, 1'b1, 1'b1, 32'hC, v);
        end
        for (int n = 0; n < 4; n++) begin
            s = 4'(1 << n);
            v = 32'(32'h1111_1111 * (n + 1));
            step(s, 1'b0, 1'b0, 32'hC, 32'h0);
            step(s, 1'b1, 1'b0, 32'hC, 32'h0);
            chk("b2b readback", Prdata, v);
        end
        idle();

        // multi-bit select: flagged once, nothing written
        do_reset();
        step(4'b0001, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
        step(4'b0001, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
        step(4'b0101, 1'b0, 1'b1, 32'h10, 32'h0BAD_0BAD);
        chk("multi prot_err", 32'(prot_err), 32'h1);
        chk("multi err_cnt",  32'(err_cnt),  32'h1);
        idle();
        step(4'b0001, 1'b0, 1'b0, 32'h10, 32'h0);
        step(4'b0001, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("multi slave0 intact", Prdata, 32'h1234_5678);
        step(4'b0100, 1'b0, 1'b0, 32'h10, 32'h0);
        step(4'b0100, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("multi slave2 intact", Prdata, RV);
        idle();

        // address changes between setup and access
        step(4'b0100, 1'b0, 1'b1, 32'h14, 32'h0000_CAFE);
        step(4'b0100, 1'b1, 1'b1, 32'h18, 32'h0000_CAFE);
        chk("addrchg prot_err",  32'(prot_err),  32'h1);
        chk("addrchg xfer_done", 32'(xfer_done), 32'h0);
        idle();
        step(4'b0100, 1'b0, 1'b1, 32'h18, 32'h7777_7777);
        step(4'b0100, 1'b1, 1'b1, 32'h18, 32'h7777_7777);
        chk("addrchg next xfer", 32'(xfer_done), 32'h1);
        step(4'b0100, 1'b0, 1'b0, 32'h14, 32'h0);
        step(4'b0100, 1'b1, 1'b0, 32'h14, 32'h0);
        chk("addrchg no write", Prdata, RV);
        step(4'b0100, 1'b0, 1'b0, 32'h18, 32'h0);
        step(4'b0100, 1'b1, 1'b0, 32'h18, 32'h0);
        chk("addrchg good write", Prdata, 32'h7777_7777);
        idle();

        // 260 Penable-without-setup cycles saturate the counter
        for (int n = 0; n < 260; n++) step(4'b0001, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("sat err_cnt",  32'(err_cnt),  32'd255);
        chk("sat prot_err", 32'(prot_err), 32'h1);
        idle();
        chk("sat hold err_cnt", 32'(err_cnt), 32'd255);

        // reset asserted during the access cycle of a write to 0x0C
        step(4'b1000, 1'b0, 1'b1, 32'hC, 32'hFFFF_0000);
        step(4'b1000, 1'b1, 1'b1, 32'hC, 32'hFFFF_0000);
        Hresetn = 1'b0;
        #1;
        chk("arst Prdata",    Prdata,         32'h0);
        chk("arst xfer_done", 32'(xfer_done), 32'h0);
        chk("arst prot_err",  32'(prot_err),  32'h0);
        chk("arst err_cnt",   32'(err_cnt),   32'h0);
        model_reset();
        Pselx = 4'd0; Penable = 1'b0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        step(4'b1000, 1'b0, 1'b0, 32'hC, 32'h0);
        step(4'b1000, 1'b1, 1'b0, 32'hC, 32'h0);
        chk("arst word reset", Prdata, RV);
        idle();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            s    = 4'(1 << $urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            a    = $urandom;
            d    = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            if (kind <= 5) begin
                step(s, 1'b0, wr, a, d);
                step(s, 1'b1, wr, a, d);
            end else if (kind == 6) begin
                idle();
            end else if (kind == 7) begin
                step(s, 1'b0, wr, a, d);
                step(s, 1'b1, wr, a, d ^ 32'h1);
            end else begin
                step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), wr, a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
